// File: rtl/uart_rx_core_if.sv
// Parallel-side and serial-line signals of the UART receiver.
// master is the receiver core; slave is whatever drives the line and consumes the words.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 i_data;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_busy;

    modport master (
        input  i_data,
        output o_data,
        output o_valid,
        output o_parity_err,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        output i_data,
        input  o_data,
        input  o_valid,
        input  o_parity_err,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: centre-samples each bit of the synchronised line
// and delivers every frame as a parallel word with parity and framing status.
module uart_rx_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_rx_core_if.master   bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0]       PAR_MODE  = 2'(PARITY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic p);
        logic err;
        case (PAR_MODE)
            2'd1:    err = ~(^d ^ p);
            2'd2:    err = (^d ^ p);
            default: err = 1'b0;
        endcase
        return err;
    endfunction

    logic                 sync1_r;
    logic                 rx_r;
    logic                 prev_rx_r;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 ferr_acc_r;
    logic                 armed_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 busy_r;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_r   <= 1'b1;
            rx_r      <= 1'b1;
            prev_rx_r <= 1'b1;
        end else begin
            sync1_r   <= bus.i_data;
            rx_r      <= sync1_r;
            prev_rx_r <= rx_r;
        end
    end

    // Frame FSM with bit timing, shift register and registered status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= '0;
            stop_idx_r <= 1'b0;
            shift_r    <= '0;
            par_bit_r  <= 1'b0;
            ferr_acc_r <= 1'b0;
            armed_r    <= 1'b0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (rx_r) begin
                        armed_r <= 1'b1;
                    end
                    // A line that was low before arming (reset, break) never counts as a start.
                    if (armed_r && prev_rx_r && !rx_r) begin
                        state_r <= ST_START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        if (rx_r) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {rx_r, shift_r[DATA_BITS-1:1]};
                        if (bit_idx_r == IDX_LAST) begin
                            bit_idx_r  <= '0;
                            stop_idx_r <= 1'b0;
                            ferr_acc_r <= 1'b0;
                            state_r    <= (PAR_MODE != 2'd0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r     <= '0;
                        par_bit_r <= rx_r;
                        state_r   <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r <= '0;
                        if (stop_idx_r == STOP_LAST) begin
                            // Back to IDLE now so a start in the second half of the stop bit is caught.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            valid_r <= 1'b1;
                            data_r  <= shift_r;
                            perr_r  <= parity_err_f(shift_r, par_bit_r);
                            ferr_r  <= ferr_acc_r | ~rx_r;
                            if (!rx_r) begin
                                armed_r <= 1'b0;
                            end
                        end else begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                            ferr_acc_r <= ferr_acc_r | ~rx_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data       = data_r;
    assign bus.o_valid      = valid_r;
    assign bus.o_parity_err = perr_r;
    assign bus.o_frame_err  = ferr_r;
    assign bus.o_busy       = busy_r;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1/16 instance and an 8E2/16 instance, checked every
// cycle against a frame-level model of busy windows, valid strobes and held outputs.
module tb_uart_rx_core;
    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int FA = 1 + 8 + 0 + 1;
    localparam int FB = 1 + 8 + 1 + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_rx_core_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_core_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_core #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a)
    );
    uart_rx_core #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One expected activity per start edge: busy window and optional delivered word.
    typedef struct {
        int         ch;
        int         t_busy;
        int         t_end;
        bit         has_out;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        bit         live;
    } ev_t;

    ev_t evs[$];
    int  va_cyc[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_at(input int c, input int t, output logic busy, output logic valid,
                                     output logic [7:0] data, output logic perr, output logic ferr);
        int best;
        best  = -1;
        busy  = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        perr  = 1'b0;
        ferr  = 1'b0;
        foreach (evs[i]) begin
            if (evs[i].live && evs[i].ch == c) begin
                if (t >= evs[i].t_busy && t < evs[i].t_end) busy = 1'b1;
                if (evs[i].has_out && evs[i].t_end <= t && evs[i].t_end > best) begin
                    best  = evs[i].t_end;
                    data  = evs[i].data;
                    perr  = evs[i].perr;
                    ferr  = evs[i].ferr;
                    valid = (evs[i].t_end == t);
                end
            end
        end
    endfunction

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin : cmp
        logic eb, ev, ep, ef;
        logic [7:0] ed;
        model_at(0, cyc, eb, ev, ed, ep, ef);
        chk("a_valid", bus_a.o_valid, ev);
        chk("a_busy", bus_a.o_busy, eb);
        chk("a_data", bus_a.o_data, ed);
        chk("a_perr", bus_a.o_parity_err, ep);
        chk("a_ferr", bus_a.o_frame_err, ef);
        if (bus_a.o_valid === 1'b1) va_cyc.push_back(cyc);
        model_at(1, cyc, eb, ev, ed, ep, ef);
        chk("b_valid", bus_b.o_valid, ev);
        chk("b_busy", bus_b.o_busy, eb);
        chk("b_data", bus_b.o_data, ed);
        chk("b_perr", bus_b.o_parity_err, ep);
        chk("b_ferr", bus_b.o_frame_err, ef);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int ch, input logic v);
        if (ch == 0) bus_a.i_data = v;
        else         bus_b.i_data = v;
    endtask

    function automatic int vc_at(input int back);
        if (va_cyc.size() > back) return va_cyc[va_cyc.size() - 1 - back];
        return -100000;
    endfunction

    // Drive one frame (ch 0: 8N1, ch 1: 8E2) and record what it must produce.
    task automatic send_frame(input int ch, input logic [7:0] d, input logic par,
                              input logic [1:0] stops, output int e0);
        ev_t e;
        int  nf;
        nf        = (ch == 0) ? FA : FB;
        e0        = cyc + 1;
        e.ch      = ch;
        e.t_busy  = e0 + 2;
        e.t_end   = e0 + 2 + H + (nf - 1) * C;
        e.has_out = 1'b1;
        e.data    = d;
        e.perr    = (ch == 1) ? logic'(($countones({d, par}) % 2) == 1) : 1'b0;
        e.ferr    = (ch == 0) ? !stops[0] : (!stops[0] || !stops[1]);
        e.live    = 1'b1;
        evs.push_back(e);
        set_line(ch, 1'b0);
        tick(C);
        for (int i = 0; i < 8; i++) begin
            set_line(ch, d[i]);
            tick(C);
        end
        if (ch == 1) begin
            set_line(ch, par);
            tick(C);
        end
        set_line(ch, stops[0]);
        tick(C);
        if (ch == 1) begin
            set_line(ch, stops[1]);
            tick(C);
        end
    endtask

    initial begin
        int   e0, e1, n0;
        ev_t  g;
        bus_a.i_data = 1'b1;
        bus_b.i_data = 1'b1;
        tick(4);
        chk("rst_data", bus_a.o_data, 32'h0);
        chk("rst_busy", bus_a.o_busy, 32'h0);
        rst = 1'b0;
        tick(20);

        send_frame(0, 8'hA5, 1'b0, 2'b11, e0);
        tick(10);
        chk("a5_data", bus_a.o_data, 32'hA5);
        chk("a5_ferr", bus_a.o_frame_err, 32'h0);
        chk("a5_busy", bus_a.o_busy, 32'h0);
        chk("a5_latency", vc_at(0) - e0, 154);

        n0 = va_cyc.size();
        send_frame(0, 8'h00, 1'b0, 2'b11, e0);
        send_frame(0, 8'hFF, 1'b0, 2'b11, e1);
        tick(10);
        chk("b2b_count", va_cyc.size() - n0, 2);
        chk("b2b_gap", vc_at(0) - vc_at(1), 160);
        chk("b2b_data", bus_a.o_data, 32'hFF);

        n0        = va_cyc.size();
        e0        = cyc + 1;
        g.ch      = 0;
        g.t_busy  = e0 + 2;
        g.t_end   = e0 + 2 + H;
        g.has_out = 1'b0;
        g.data    = 8'h00;
        g.perr    = 1'b0;
        g.ferr    = 1'b0;
        g.live    = 1'b1;
        evs.push_back(g);
        set_line(0, 1'b0);
        tick(4);
        set_line(0, 1'b1);
        tick(2);
        chk("glitch_busy_hi", bus_a.o_busy, 32'h1);
        tick(28);
        chk("glitch_busy_lo", bus_a.o_busy, 32'h0);
        chk("glitch_no_valid", va_cyc.size() - n0, 0);
        send_frame(0, 8'h3C, 1'b0, 2'b11, e0);
        tick(10);
        chk("after_glitch", bus_a.o_data, 32'h3C);

        n0 = va_cyc.size();
        send_frame(0, 8'h55, 1'b0, 2'b00, e0);
        tick(40);
        chk("brk_ferr", bus_a.o_frame_err, 32'h1);
        chk("brk_data", bus_a.o_data, 32'h55);
        chk("brk_one_valid", va_cyc.size() - n0, 1);
        set_line(0, 1'b1);
        tick(20);
        send_frame(0, 8'h3C, 1'b0, 2'b11, e0);
        tick(10);
        chk("post_brk_ferr", bus_a.o_frame_err, 32'h0);

        n0        = va_cyc.size();
        e0        = cyc + 1;
        g.t_busy  = e0 + 2;
        g.t_end   = e0 + 2 + H + (FA - 1) * C;
        g.has_out = 1'b1;
        g.data    = 8'h81;
        evs.push_back(g);
        set_line(0, 1'b0);
        tick(C);
        for (int i = 0; i < 4; i++) begin
            set_line(0, g.data[i]);
            tick(C);
        end
        set_line(0, g.data[4]);
        tick(5);
        #2;
        rst = 1'b1;
        foreach (evs[i]) evs[i].live = 1'b0;
        #1;
        chk("arst_data", bus_a.o_data, 32'h0);
        chk("arst_busy", bus_a.o_busy, 32'h0);
        chk("arst_valid", bus_a.o_valid, 32'h0);
        set_line(0, 1'b1);
        tick(3);
        rst = 1'b0;
        tick(30);
        chk("arst_no_valid", va_cyc.size() - n0, 0);
        send_frame(0, 8'h3C, 1'b0, 2'b11, e0);
        tick(10);
        chk("arst_recover", bus_a.o_data, 32'h3C);

        send_frame(1, 8'h07, 1'b0, 2'b11, e0);
        tick(10);
        chk("par0_perr", bus_b.o_parity_err, 32'h1);
        chk("par0_data", bus_b.o_data, 32'h07);
        send_frame(1, 8'h07, 1'b1, 2'b11, e0);
        tick(10);
        chk("par1_perr", bus_b.o_parity_err, 32'h0);
        send_frame(1, 8'h07, 1'b1, 2'b01, e0);
        tick(10);
        chk("stop2_ferr", bus_b.o_frame_err, 32'h1);
        chk("stop2_perr", bus_b.o_parity_err, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver for the serial-interface layer. It oversamples an asynchronous serial line with the system clock and samples each bit at its centre. Each received frame is presented as a parallel word with a one-cycle valid strobe plus parity and framing status. Data width, baud divisor, parity mode and stop-bit count are compile-time parameters; start-bit glitch rejection and error reporting are included.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, i_clk cycles per serial bit; even, ≥ 4. H = CLKS_PER_BIT/2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- i_clk  in  1  single system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  1  serial line, idle high, LSB first, asynchronous to i_clk.
- o_data  out  DATA_BITS  last received word; holds until the next o_valid.
- o_valid  out  1  one-cycle pulse per completed frame.
- o_parity_err  out  1  parity mismatch of the frame flagged by o_valid; 0 when PARITY=0.
- o_frame_err  out  1  some stop-bit sample of the frame flagged by o_valid was 0.
- o_busy  out  1  high in every state except IDLE.

## Operation
- i_data passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised line (rx).
- Reset values:
  - o_data = 0, o_valid = 0, o_parity_err = 0, o_frame_err = 0, o_busy = 0.
  - FSM = IDLE, counters = 0, armed = 0.
- armed: set when rx = 1 is seen in IDLE; cleared by reset and by any frame end with rx = 0. Start detection requires armed = 1, prev rx = 1 and rx = 0. A line held low through reset or a break is therefore never taken as a start.
- FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- START: the cycle counter runs from 0. At count H−1 (mid start bit), rx is sampled:
  - rx = 1 (glitch): return to IDLE, no output.
  - rx = 0: go to DATA; the counter reloads so the next samples fall every CLKS_PER_BIT cycles.
- DATA: samples DATA_BITS bits into the shift register, LSB first. A bit index counts 0..DATA_BITS−1.
- PARITY: samples one bit.
  - Odd mode: error if XOR(data, parity bit) = 0.
  - Even mode: error if XOR(data, parity bit) = 1.
- STOP: samples STOP_BITS bits. Any 0 sets the frame error.
- After the last stop sample:
  - Next cycle: o_data, o_parity_err and o_frame_err load together and o_valid = 1 for exactly that cycle.
  - The FSM returns to IDLE in the same cycle, so a start edge in the second half of the stop bit is accepted.
- Erroneous frames are still delivered. o_data carries the sampled bits and the error flags are set.
- The error flags are meaningful only with o_valid and hold between frames.
- Reset mid-frame: the partial frame is discarded, no o_valid is issued, and outputs take their reset values.

## Timing
- Let E0 be the first i_clk edge that registers i_data = 0 (start bit).
  - rx falls at E0+2; START is entered at that edge.
  - Sample k (k=0 start, 1..DATA_BITS data, then parity, then stop) occurs at edge E0 + 2 + H + k·CLKS_PER_BIT.
- F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS. o_valid is high in the cycle after edge E0 + 2 + H + (F−1)·CLKS_PER_BIT.
  - Default 8N1/16: o_valid is high at E0+155.
- o_busy rises at E0+3 and falls in the o_valid cycle.
- Back-to-back frames with zero idle gap are received without loss.
- Sampling tolerates ±(H−2) cycles of accumulated bit-edge error per frame.

## Test plan
- Defaults, frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) → o_data = 0xA5 with o_valid at E0+155, both error flags 0, o_busy low afterwards.
- Defaults, frames 0x00 then 0xFF back-to-back with no idle gap → two o_valid pulses exactly 160 cycles apart, data 0x00 then 0xFF.
- Defaults, i_data low for 4 cycles then high → no o_valid; o_busy high briefly then 0; a following 0x3C frame is received correctly.
- PARITY=2, frame 0x07 with parity bit 0 → o_data = 0x07, o_parity_err = 1. The same frame with parity bit 1 → o_parity_err = 0. With STOP_BITS=2, second stop bit 0 → o_frame_err = 1.
- Defaults, 0x55 with stop bit 0 and the line held low for 40 cycles → o_valid with o_frame_err = 1. No new frame starts until the line returns high and then falls.
- Reset asserted asynchronously after the 4th data bit of 0x81 → outputs 0 immediately, no o_valid. After release and idle, frame 0x3C → o_data = 0x3C, no errors.
